// File: rtl/acc_drain_unit_pkg.sv
// Shared definitions for the accumulator drain unit.
//   state_t    : drain FSM state encoding (S_IDLE, S_SCAN, S_WRITE, S_DONE)
//   core_idx_w : width of a core index for a given core count (never below 1)
package acc_drain_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic int core_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_drain_unit_rr_pick.sv
// Round-robin first-set finder (rr_pick).
// Searches a request vector starting at index ptr and wrapping modulo
// num_cores. It reports whether any request is set and, if so, the first
// set index at or after ptr.
//   req   in  num_cores  request vector
//   ptr   in  idx_width  search start index (< num_cores)
//   found out 1          at least one request set
//   idx   out idx_width  granted index (0 when found=0)
module acc_drain_unit_rr_pick
  import acc_drain_unit_pkg::*;
#(
  parameter int num_cores = 4,
  parameter int idx_width = core_idx_w(num_cores)
) (
  input  logic [num_cores-1:0] req,
  input  logic [idx_width-1:0] ptr,
  output logic                 found,
  output logic [idx_width-1:0] idx
);

  logic [idx_width:0] pos;

  // Walk offsets from the farthest to the nearest so the nearest set
  // request after ptr is the last one written and therefore wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = num_cores - 1; i >= 0; i--) begin
      pos = {1'b0, ptr} + (idx_width + 1)'(i);
      if (pos >= (idx_width + 1)'(num_cores)) begin
        pos = pos - (idx_width + 1)'(num_cores);
      end
      if (req[pos[idx_width-1:0]]) begin
        found = 1'b1;
        idx   = pos[idx_width-1:0];
      end
    end
  end

endmodule

// File: rtl/acc_drain_unit.sv
// Accumulator drain unit.
// Collects the final accumulator value of each multiplier core and writes
// them to consecutive result-memory addresses starting at base_addr. Valid
// cores are granted round-robin; each core is served once per run and is
// acknowledged with a one-cycle pulse in the same cycle as its write.
//   clk, rst_n  clock, asynchronous active-low reset
//   start       begin a run (only honoured in IDLE); base_addr latched then
//   core_valid  per-core result-ready flags
//   core_data   packed core values, core i at [i*data_width +: data_width]
//   core_ack    one-hot pulse, core i value taken
//   mem_addr, mem_data, mem_we   result memory write port
//   busy        run in progress; done  one-cycle end-of-run pulse
//   count       cores written in the current run
module acc_drain_unit
  import acc_drain_unit_pkg::*;
#(
  parameter int data_width = 16,
  parameter int addr_width = 8,
  parameter int num_cores  = 4,
  parameter int idx_width  = core_idx_w(num_cores)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [addr_width-1:0]           base_addr,
  input  logic [num_cores-1:0]            core_valid,
  input  logic [num_cores*data_width-1:0] core_data,
  output logic [num_cores-1:0]            core_ack,
  output logic [addr_width-1:0]           mem_addr,
  output logic [data_width-1:0]           mem_data,
  output logic                            mem_we,
  output logic                            busy,
  output logic                            done,
  output logic [idx_width:0]              count
);

  state_t                  state, state_nxt;
  logic [num_cores-1:0]    served_mask, mask_nxt;
  logic [idx_width-1:0]    rr_ptr, rr_nxt;
  logic [addr_width-1:0]   addr_ptr, addr_nxt;
  logic [idx_width:0]      count_nxt;
  logic [addr_width-1:0]   mem_addr_nxt;
  logic [data_width-1:0]   mem_data_nxt;
  logic                    mem_we_nxt, busy_nxt, done_nxt;
  logic [num_cores-1:0]    ack_nxt;

  logic                    pick_found;
  logic [idx_width-1:0]    pick_idx;
  logic [data_width-1:0]   core_word [num_cores];

  for (genvar g = 0; g < num_cores; g++) begin : g_unpack
    assign core_word[g] = core_data[g*data_width +: data_width];
  end

  // Cores already written this run are masked so a held valid is not re-served.
  acc_drain_unit_rr_pick #(
    .num_cores (num_cores),
    .idx_width (idx_width)
  ) u_pick (
    .req   (core_valid & ~served_mask),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nxt    = state;
    mask_nxt     = served_mask;
    rr_nxt       = rr_ptr;
    addr_nxt     = addr_ptr;
    count_nxt    = count;
    mem_addr_nxt = mem_addr;
    mem_data_nxt = mem_data;
    mem_we_nxt   = 1'b0;
    ack_nxt      = '0;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          addr_nxt  = base_addr;
          count_nxt = '0;
          mask_nxt  = '0;
          busy_nxt  = 1'b1;
          state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (pick_found) begin
          mem_data_nxt      = core_word[pick_idx];
          mem_addr_nxt      = addr_ptr;
          mem_we_nxt        = 1'b1;
          ack_nxt[pick_idx] = 1'b1;
          mask_nxt[pick_idx] = 1'b1;
          rr_nxt = (pick_idx == idx_width'(num_cores - 1)) ? '0 : pick_idx + 1'b1;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_nxt  = addr_ptr + 1'b1;
        count_nxt = count + 1'b1;
        if (count_nxt == (idx_width + 1)'(num_cores)) begin
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_SCAN;
        end
      end
      S_DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      served_mask <= '0;
      rr_ptr      <= '0;
      addr_ptr    <= '0;
      count       <= '0;
      mem_addr    <= '0;
      mem_data    <= '0;
      mem_we      <= 1'b0;
      core_ack    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      served_mask <= mask_nxt;
      rr_ptr      <= rr_nxt;
      addr_ptr    <= addr_nxt;
      count       <= count_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_data    <= mem_data_nxt;
      mem_we      <= mem_we_nxt;
      core_ack    <= ack_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_acc_drain_unit.sv
// Testbench for acc_drain_unit: directed runs, expected writes queued at
// stimulus time and consumed by a monitor on every mem_we cycle.
module tb_acc_drain_unit;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int NC = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [NC-1:0]     core_valid;
  logic [NC*DW-1:0]  core_data;
  logic [NC-1:0]     core_ack;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_data;
  logic              mem_we;
  logic              busy;
  logic              done;
  logic [IW:0]       count;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_seen = 0;
  int   cyc = 0;
  int   snap;

  acc_drain_unit #(
    .data_width (DW),
    .addr_width (AW),
    .num_cores  (NC),
    .idx_width  (IW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .core_valid (core_valid),
    .core_data  (core_data),
    .core_ack   (core_ack),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .busy       (busy),
    .done       (done),
    .count      (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic push(input int idx, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    exp_t e;
    e.idx  = IW'(idx);
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic set_data(input logic [DW-1:0] b);
    for (int i = 0; i < NC; i++) core_data[i*DW +: DW] = b + DW'(i);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // cyc 0 is the cycle in which start is high; the run begins on its closing edge.
  task automatic start_run(input logic [AW-1:0] b);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = b;
    cyc = 0;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input string name, input int exp_cyc);
    int d0;
    int got;
    d0  = done_seen;
    got = -1;
    for (int n = 0; n < 80 && got < 0; n++) begin
      if (done) got = cyc;
      else tick();
    end
    if (got < 0) begin
      check({name, "_done_timeout"}, done, 1);
    end else begin
      if (exp_cyc >= 0) check({name, "_done_cycle"}, got, exp_cyc);
      check({name, "_count_at_done"}, count, 4);
      tick();
      check({name, "_busy_after_done"}, busy, 0);
      check({name, "_done_pulse_width"}, done, 0);
      check({name, "_done_once"}, done_seen - d0, 1);
    end
    check({name, "_all_writes_seen"}, exp_q.size(), 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    core_valid = '1;
    core_data  = '0;
    set_data(16'h0100);

    fork
      forever begin
        @(negedge clk);
        if (rst_n && mem_we) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", mem_we, 0);
          end else begin
            mon_e = exp_q.pop_front();
            check("write_addr", mem_addr, mon_e.addr);
            check("write_data", mem_data, mon_e.data);
            check("write_ack_onehot", core_ack, NC'(1) << mon_e.idx);
          end
        end else if (core_ack != '0) begin
          check("ack_without_write", core_ack, 0);
        end
        if (done) done_seen++;
      end
    join_none

    // Test 1: reset state with all valids high, then a full in-order run.
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_we", mem_we, 0);
    check("rst_core_ack", core_ack, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle_no_write", mem_we, 0);
    push(0, 8'h10, 16'h0100);
    push(1, 8'h11, 16'h0101);
    push(2, 8'h12, 16'h0102);
    push(3, 8'h13, 16'h0103);
    start_run(8'h10);
    wait_done("t1", 9);

    // Test 2: staggered valids, SCAN idles between them.
    set_data(16'h0200);
    core_valid = 4'b0100;
    push(2, 8'h20, 16'h0202);
    push(0, 8'h21, 16'h0200);
    push(1, 8'h22, 16'h0201);
    push(3, 8'h23, 16'h0203);
    start_run(8'h20);
    repeat (5) tick();
    check("t2_count_wait1", count, 1);
    check("t2_busy_wait1", busy, 1);
    core_valid = 4'b0101;
    repeat (5) tick();
    check("t2_count_wait2", count, 2);
    core_valid = 4'b1111;
    wait_done("t2", -1);

    // Test 3: address wrap at the top of memory; outputs hold afterwards.
    set_data(16'h0300);
    push(0, 8'hFE, 16'h0300);
    push(1, 8'hFF, 16'h0301);
    push(2, 8'h00, 16'h0302);
    push(3, 8'h01, 16'h0303);
    start_run(8'hFE);
    wait_done("t3", 9);
    repeat (2) tick();
    check("t3_count_hold", count, 4);
    check("t3_addr_hold", mem_addr, 8'h01);
    check("t3_data_hold", mem_data, 16'h0303);

    // Test 4: held valids, start pulsed mid-run, core data changed after grant.
    set_data(16'h0400);
    push(0, 8'h40, 16'h0400);
    push(1, 8'h41, 16'h0401);
    push(2, 8'h42, 16'h0402);
    push(3, 8'h43, 16'h0403);
    start_run(8'h40);
    tick();
    core_data[DW-1:0] = 16'hDEAD;
    tick();
    start = 1'b1;
    base_addr = 8'h80;
    tick();
    start = 1'b0;
    wait_done("t4", 9);
    repeat (4) tick();
    check("t4_no_restart", busy, 0);

    // Test 5: asynchronous reset during the second write, then a clean run.
    set_data(16'h0500);
    push(0, 8'h50, 16'h0500);
    push(1, 8'h51, 16'h0501);
    start_run(8'h50);
    repeat (3) tick();
    check("t5_in_second_write", mem_we, 1);
    @(negedge clk);
    #1;
    snap = done_seen;
    rst_n = 1'b0;
    #1;
    check("t5_rst_mem_we", mem_we, 0);
    check("t5_rst_core_ack", core_ack, 0);
    check("t5_rst_busy", busy, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("t5_no_done", done_seen - snap, 0);
    check("t5_writes_before_reset", exp_q.size(), 0);
    set_data(16'h0600);
    core_valid = 4'b1110;
    push(1, 8'h60, 16'h0601);
    push(2, 8'h61, 16'h0602);
    push(3, 8'h62, 16'h0603);
    push(0, 8'h63, 16'h0600);
    start_run(8'h60);
    repeat (7) tick();
    check("t5_count_wait", count, 3);
    core_valid = 4'b1111;
    wait_done("t5", -1);

    // Test 6: round-robin pointer carried over from the previous run.
    set_data(16'h0700);
    push(1, 8'h70, 16'h0701);
    push(2, 8'h71, 16'h0702);
    push(3, 8'h72, 16'h0703);
    push(0, 8'h73, 16'h0700);
    start_run(8'h70);
    wait_done("t6", 9);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
